// File: rtl/sha_sched_pkg.sv
// Shared types for the SHA job scheduler: FSM states, job/solution records and the tag helper.
// Job IDs are carried at ID_MAX_W bits; the scheduler uses the low JOB_ID_W bits.
package sha_sched_pkg;

  localparam int unsigned PIPE_LAT_DEF = 131;
  localparam int unsigned ID_MAX_W     = 16;
  // Wide enough for N + PIPE_LAT - 1 with N up to 2^32.
  localparam int unsigned CYC_W        = 34;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } sched_state_e;

  typedef struct packed {
    logic [255:0]          digest_init;
    logic [255:0]          midstate;
    logic [31:0]           merkle;
    logic [31:0]           ntime;
    logic [31:0]           target;
    logic [31:0]           nonce_start;
    logic [31:0]           nonce_end;
    logic [ID_MAX_W-1:0]   id;
  } job_t;

  typedef struct packed {
    logic [31:0]           nonce;
    logic [31:0]           ntime;
    logic [ID_MAX_W-1:0]   id;
  } sol_t;

  // Nonce overflow carries into ntime, matching the hasher's own increment.
  function automatic logic [63:0] sol_tag(logic [31:0] ntime, logic [31:0] nonce,
                                          logic [CYC_W-1:0] k);
    return {ntime, nonce} + {{(64 - CYC_W){1'b0}}, k};
  endfunction

endpackage

// File: rtl/sha_sol_fifo.sv
// First-word-fall-through FIFO of tagged solutions; a push into a full FIFO without a pop
// is dropped and latches a sticky overflow flag.
module sha_sol_fifo
  import sha_sched_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  sol_t push_data,
  input  logic pop,
  output sol_t head,
  output logic full,
  output logic empty,
  output logic overflow
);
  localparam int unsigned AW = $clog2(Depth);

  sol_t        mem_q [Depth];
  logic [AW:0] wptr_q, rptr_q;
  logic        ovf_q;
  logic        do_push, do_pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= push_data;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !do_push) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_job_scheduler.sv
// Double-buffers mining jobs, sequences the hasher over a nonce range and tags its solution
// flags with nonce/time/job ID. Define SCHED_TIME_ROLL_EN to rescan with ntime+1 when idle.
module sha_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF,
  parameter int unsigned SOL_DEPTH = 4,
  parameter int unsigned JOB_ID_W  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [255:0]        job_digest_init,
  input  logic [255:0]        job_midstate,
  input  logic [31:0]         job_merkle,
  input  logic [31:0]         job_time,
  input  logic [31:0]         job_target,
  input  logic [31:0]         job_nonce_start,
  input  logic [31:0]         job_nonce_end,
  input  logic                abort,
  output logic                hs_rst_n,
  output logic                hs_write_en,
  output logic [255:0]        hs_digest_initial,
  output logic [255:0]        hs_digest_in,
  output logic [31:0]         hs_merkle,
  output logic [31:0]         hs_time,
  output logic [31:0]         hs_target,
  output logic [31:0]         hs_nonce,
  input  logic                hs_valid,
  output logic                sol_valid,
  input  logic                sol_ready,
  output logic [31:0]         sol_nonce,
  output logic [31:0]         sol_time,
  output logic [JOB_ID_W-1:0] sol_job_id,
  output logic                busy,
  output logic                sol_overflow
);
  localparam logic [CYC_W-1:0] PipeLat = CYC_W'(PIPE_LAT);

  sched_state_e        state_q, state_d;
  job_t                act_q, act_d, pend_q, pend_d, in_job;
  logic                pend_full_q, pend_full_d;
  logic [JOB_ID_W-1:0] id_q, id_d;
  logic [CYC_W-1:0]    c_q, c_d, n_ext;
  logic [32:0]         n_q, n_d;
  logic                job_hs, handoff, roll, capture, run_or_drain;
  logic [63:0]         tag;
  sol_t                sol_in, sol_head;
  logic                sol_empty, unused_sol_full, unused_head_id;

  assign job_ready    = ~pend_full_q;
  assign job_hs       = job_valid & job_ready;
  assign run_or_drain = (state_q == StRun) || (state_q == StDrain);
  assign n_ext        = {1'b0, n_q};

  assign in_job = '{digest_init: job_digest_init, midstate: job_midstate, merkle: job_merkle,
                    ntime: job_time, target: job_target, nonce_start: job_nonce_start,
                    nonce_end: job_nonce_end, id: ID_MAX_W'(id_q)};

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    c_d         = c_q;
    n_d         = n_q;
    handoff     = 1'b0;
    roll        = 1'b0;

    unique case (state_q)
      StIdle: begin
        handoff = pend_full_q;
      end
      StLoad, StRun, StDrain: begin
        if (abort) begin
          handoff = pend_full_q;
          if (!pend_full_q) state_d = StIdle;
        end else if (state_q == StLoad) begin
          c_d     = '0;
          n_d     = {1'b0, act_q.nonce_end - act_q.nonce_start} + 33'd1;
          state_d = StRun;
        end else begin
          c_d = c_q + 1'b1;
          if (state_q == StRun && c_q == n_ext - 1'b1) begin
            state_d = StDrain;
          end
          if (state_q == StDrain && c_q == n_ext + PipeLat - 1'b1) begin
            handoff = pend_full_q;
            if (!pend_full_q) begin
`ifdef SCHED_TIME_ROLL_EN
              roll    = 1'b1;
`else
              state_d = StIdle;
`endif
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (handoff) begin
      state_d     = StLoad;
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (roll) begin
      // A job accepted this same cycle takes id_q, so the rescan takes the next ID.
      state_d     = StLoad;
      act_d.ntime = act_q.ntime + 32'd1;
      act_d.id    = ID_MAX_W'(id_q + JOB_ID_W'(job_hs));
    end
    if (job_hs) begin
      pend_d      = in_job;
      pend_full_d = 1'b1;
    end
    id_d = id_q + JOB_ID_W'(job_hs) + JOB_ID_W'(roll);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      id_q        <= '0;
      c_q         <= '0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      id_q        <= id_d;
      c_q         <= c_d;
      n_q         <= n_d;
    end
  end

  // c counts cycles since the first nonce issue, so flag at c belongs to nonce offset c-PIPE_LAT.
  assign capture = run_or_drain && !abort && hs_valid && (c_q >= PipeLat) &&
                   (c_q < n_ext + PipeLat);
  assign tag     = sol_tag(act_q.ntime, act_q.nonce_start, c_q - PipeLat);
  assign sol_in  = '{nonce: tag[31:0], ntime: tag[63:32], id: act_q.id};

  sha_sol_fifo #(
    .Depth(SOL_DEPTH)
  ) u_sol_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push     (capture),
    .push_data(sol_in),
    .pop      (sol_ready),
    .head     (sol_head),
    .full     (unused_sol_full),
    .empty    (sol_empty),
    .overflow (sol_overflow)
  );

  assign unused_head_id    = ^sol_head.id;
  assign sol_valid         = ~sol_empty;
  assign sol_nonce         = sol_head.nonce;
  assign sol_time          = sol_head.ntime;
  assign sol_job_id        = sol_head.id[JOB_ID_W-1:0];

  assign busy              = (state_q != StIdle);
  assign hs_rst_n          = (state_q != StLoad);
  assign hs_write_en       = run_or_drain;
  assign hs_digest_initial = act_q.digest_init;
  assign hs_digest_in      = act_q.midstate;
  assign hs_merkle         = act_q.merkle;
  assign hs_time           = act_q.ntime;
  assign hs_target         = act_q.target;
  assign hs_nonce          = act_q.nonce_start;

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Self-checking bench for sha_job_scheduler: directed scenarios plus randomized jobs checked
// against a queue model of tagged solutions built from the job's nonce range and flag cycles.
module tb_sha_job_scheduler;
  localparam int PL    = 8;
  localparam int DEPTH = 4;
  localparam int IDW   = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           job_valid, job_ready, abort, hs_rst_n, hs_write_en, hs_valid;
  logic [255:0]   job_digest_init, job_midstate, hs_digest_initial, hs_digest_in;
  logic [31:0]    job_merkle, job_time, job_target, job_nonce_start, job_nonce_end;
  logic [31:0]    hs_merkle, hs_time, hs_target, hs_nonce, sol_nonce, sol_time;
  logic           sol_valid, sol_ready, busy, sol_overflow;
  logic [IDW-1:0] sol_job_id;

  sha_job_scheduler #(.PIPE_LAT(PL), .SOL_DEPTH(DEPTH), .JOB_ID_W(IDW)) dut (
    .CLK(CLK), .RST(RST), .job_valid(job_valid), .job_ready(job_ready),
    .job_digest_init(job_digest_init), .job_midstate(job_midstate), .job_merkle(job_merkle),
    .job_time(job_time), .job_target(job_target), .job_nonce_start(job_nonce_start),
    .job_nonce_end(job_nonce_end), .abort(abort), .hs_rst_n(hs_rst_n),
    .hs_write_en(hs_write_en), .hs_digest_initial(hs_digest_initial),
    .hs_digest_in(hs_digest_in), .hs_merkle(hs_merkle), .hs_time(hs_time),
    .hs_target(hs_target), .hs_nonce(hs_nonce), .hs_valid(hs_valid), .sol_valid(sol_valid),
    .sol_ready(sol_ready), .sol_nonce(sol_nonce), .sol_time(sol_time),
    .sol_job_id(sol_job_id), .busy(busy), .sol_overflow(sol_overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [255:0]   dinit, mid;
    logic [31:0]    merkle, ntime, target, start, stop;
    logic [IDW-1:0] id;
  } tjob_t;
  typedef struct {
    logic [31:0]    nonce, ntime;
    logic [IDW-1:0] id;
  } tsol_t;

  tsol_t          mq[$];
  int             n_checks = 0;
  int             n_fail = 0;
  logic           exp_ovf = 1'b0;
  logic [IDW-1:0] next_id = '0;
  logic           pend_exp = 1'b0;
  tjob_t          pend_job, offer_job;
  bit             flag_at[64];
  bit             pop_at[64];
  int             offer_c, abort_c;
  bit             post_flag;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      flag_at[i] = 1'b0;
      pop_at[i]  = 1'b0;
    end
    offer_c   = -1;
    abort_c   = -1;
    post_flag = 1'b0;
  endtask

  function automatic tjob_t mk_job(logic [31:0] start, int n, logic [31:0] ntime);
    tjob_t j;
    for (int i = 0; i < 8; i++) begin
      j.dinit[i*32 +: 32] = $urandom;
      j.mid[i*32 +: 32]   = $urandom;
    end
    j.merkle = $urandom;
    j.target = $urandom;
    j.ntime  = ntime;
    j.start  = start;
    j.stop   = start + 32'(n - 1);
    j.id     = '0;
    return j;
  endfunction

  task automatic drive_job(input tjob_t j);
    job_valid       = 1'b1;
    job_digest_init = j.dinit;
    job_midstate    = j.mid;
    job_merkle      = j.merkle;
    job_time        = j.ntime;
    job_target      = j.target;
    job_nonce_start = j.start;
    job_nonce_end   = j.stop;
  endtask

  // Hand a job over from IDLE and step into its LOAD cycle.
  task automatic start_job(input tjob_t j, output tjob_t jo);
    drive_job(j);
    n_checks++;
    if (job_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_ready: got %0b want 1", job_ready);
    end
    tick();
    job_valid = 1'b0;
    jo        = j;
    jo.id     = next_id;
    next_id++;
    n_checks++;
    if (job_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pending_idle: got ready=%0b busy=%0b want 0 0", job_ready, busy);
    end
    tick();
  endtask

  // Entered in the LOAD cycle of j; returns in IDLE, or in the LOAD cycle of the pending job.
  task automatic run_from_load(input tjob_t j);
    longint      n;
    logic [63:0] tag;
    tsol_t       s;
    bit          done, fl, dp, had_pend;
    n = longint'(j.stop - j.start) + 1;
    n_checks++;
    if (hs_rst_n !== 1'b0 || hs_write_en !== 1'b0 || busy !== 1'b1 || job_ready !== !pend_exp)
    begin
      n_fail++;
      $display("FAIL load_ctrl: got rst_n=%0b we=%0b busy=%0b ready=%0b want 0 0 1 %0b",
               hs_rst_n, hs_write_en, busy, job_ready, !pend_exp);
    end
    n_checks++;
    if (hs_nonce !== j.start || hs_time !== j.ntime || hs_target !== j.target ||
        hs_merkle !== j.merkle || hs_digest_initial !== j.dinit || hs_digest_in !== j.mid) begin
      n_fail++;
      $display("FAIL load_fields: got nonce=%h time=%h want nonce=%h time=%h",
               hs_nonce, hs_time, j.start, j.ntime);
    end
    tick();
    done = 1'b0;
    for (int c = 0; c < int'(n) + PL && !done; c++) begin
      n_checks++;
      if (hs_write_en !== 1'b1 || hs_rst_n !== 1'b1 || busy !== 1'b1 || job_ready !== !pend_exp)
      begin
        n_fail++;
        $display("FAIL run_ctrl c=%0d: got we=%0b rst_n=%0b busy=%0b ready=%0b want 1 1 1 %0b",
                 c, hs_write_en, hs_rst_n, busy, job_ready, !pend_exp);
      end
      n_checks++;
      if (sol_valid !== (mq.size() != 0) || sol_overflow !== exp_ovf) begin
        n_fail++;
        $display("FAIL fifo_state c=%0d: got valid=%0b ovf=%0b want %0b %0b",
                 c, sol_valid, sol_overflow, mq.size() != 0, exp_ovf);
      end
      fl       = flag_at[c];
      dp       = pop_at[c] && mq.size() != 0;
      hs_valid = fl;
      abort    = (c == abort_c);
      if (dp) begin
        n_checks++;
        if (sol_nonce !== mq[0].nonce || sol_time !== mq[0].ntime || sol_job_id !== mq[0].id)
        begin
          n_fail++;
          $display("FAIL run_pop c=%0d: got n=%h t=%h id=%0d want n=%h t=%h id=%0d", c,
                   sol_nonce, sol_time, sol_job_id, mq[0].nonce, mq[0].ntime, mq[0].id);
        end
        sol_ready = 1'b1;
      end
      if (c == offer_c) begin
        drive_job(offer_job);
        n_checks++;
        if (job_ready !== 1'b1) begin
          n_fail++; $display("FAIL offer_ready c=%0d: got %0b want 1", c, job_ready);
        end
      end
      tick();
      hs_valid  = 1'b0;
      sol_ready = 1'b0;
      abort     = 1'b0;
      if (c == offer_c) begin
        job_valid   = 1'b0;
        pend_job    = offer_job;
        pend_job.id = next_id;
        next_id++;
        pend_exp    = 1'b1;
      end
      if (dp) void'(mq.pop_front());
      if (fl && c >= PL && c < int'(n) + PL && c != abort_c) begin
        tag     = {j.ntime, j.start} + 64'(c - PL);
        s.nonce = tag[31:0];
        s.ntime = tag[63:32];
        s.id    = j.id;
        if (mq.size() < DEPTH) mq.push_back(s);
        else exp_ovf = 1'b1;
      end
      if (c == abort_c) done = 1'b1;
    end
    had_pend = pend_exp;
    pend_exp = 1'b0;
`ifdef SCHED_TIME_ROLL_EN
    if (!done && !had_pend) begin
      n_checks++;
      if (hs_rst_n !== 1'b0 || hs_time !== j.ntime + 32'd1 || hs_nonce !== j.start) begin
        n_fail++;
        $display("FAIL roll_load: got rst_n=%0b time=%h nonce=%h want 0 %h %h",
                 hs_rst_n, hs_time, hs_nonce, j.ntime + 32'd1, j.start);
      end
      next_id++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
`endif
    n_checks++;
    if (had_pend ? (hs_rst_n !== 1'b0 || busy !== 1'b1) : (busy !== 1'b0 || hs_write_en !== 1'b0))
    begin
      n_fail++;
      $display("FAIL job_end: got rst_n=%0b busy=%0b we=%0b want %s", hs_rst_n, busy,
               hs_write_en, had_pend ? "direct LOAD" : "IDLE");
    end
    if (post_flag && !had_pend) begin
      hs_valid = 1'b1;
      tick();
      hs_valid = 1'b0;
      n_checks++;
      if (sol_valid !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL late_flag: got valid=%0b want %0b", sol_valid, mq.size() != 0);
      end
    end
  endtask

  task automatic pop_all();
    while (mq.size() != 0) begin
      n_checks++;
      if (sol_valid !== 1'b1 || sol_nonce !== mq[0].nonce || sol_time !== mq[0].ntime ||
          sol_job_id !== mq[0].id) begin
        n_fail++;
        $display("FAIL drain_pop: got v=%0b n=%h t=%h id=%0d want v=1 n=%h t=%h id=%0d",
                 sol_valid, sol_nonce, sol_time, sol_job_id, mq[0].nonce, mq[0].ntime, mq[0].id);
      end
      sol_ready = 1'b1;
      tick();
      sol_ready = 1'b0;
      void'(mq.pop_front());
    end
    n_checks++;
    if (sol_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got valid=%0b want 0", sol_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (job_ready !== 1'b1 || hs_rst_n !== 1'b1 || hs_write_en !== 1'b0 || sol_valid !== 1'b0 ||
        busy !== 1'b0 || sol_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%0b rst_n=%0b we=%0b sv=%0b busy=%0b ovf=%0b want 1 1 0 0 0 0",
               job_ready, hs_rst_n, hs_write_en, sol_valid, busy, sol_overflow);
    end
    n_checks++;
    if (hs_nonce !== '0 || hs_time !== '0 || hs_target !== '0 || hs_merkle !== '0 ||
        hs_digest_initial !== '0 || hs_digest_in !== '0) begin
      n_fail++; $display("FAIL reset_data: got nonce=%h time=%h want 0", hs_nonce, hs_time);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    tjob_t j;
    clear_stim();
    flag_at[10] = 1'b1;
    start_job(mk_job(32'h100, 4, $urandom), j);
    run_from_load(j);
    n_checks++;
    if (sol_nonce !== 32'h102 || sol_time !== j.ntime) begin
      n_fail++; $display("FAIL basic_tag: got n=%h t=%h want n=102 t=%h", sol_nonce, sol_time, j.ntime);
    end
    pop_all();
  endtask

  task automatic test_wrap();
    tjob_t j;
    clear_stim();
    flag_at[PL+3] = 1'b1;
    flag_at[PL]   = 1'b1;
    start_job(mk_job(32'hFFFF_FFFE, 4, 32'h5000), j);
    run_from_load(j);
    pop_all();
    clear_stim();
    flag_at[PL+3] = 1'b1;
    start_job(mk_job(32'hFFFF_FFFE, 4, 32'h5000), j);
    run_from_load(j);
    n_checks++;
    if (sol_nonce !== 32'h1 || sol_time !== 32'h5001) begin
      n_fail++; $display("FAIL wrap_tag: got n=%h t=%h want n=1 t=5001", sol_nonce, sol_time);
    end
    pop_all();
    clear_stim();
    flag_at[PL] = 1'b1;
    flag_at[PL+1] = 1'b1;
    start_job(mk_job($urandom, 1, $urandom), j);
    run_from_load(j);
    pop_all();
  endtask

  task automatic test_back_to_back();
    tjob_t a, b;
    clear_stim();
    offer_c       = 2;
    offer_job     = mk_job($urandom, 3, $urandom);
    flag_at[PL]   = 1'b1;
    start_job(mk_job($urandom, 3, $urandom), a);
    run_from_load(a);
    b = pend_job;
    clear_stim();
    flag_at[PL+1] = 1'b1;
    run_from_load(b);
    n_checks++;
    if (sol_job_id !== a.id) begin
      n_fail++; $display("FAIL b2b_id_a: got %0d want %0d", sol_job_id, a.id);
    end
    pop_all();
  endtask

  task automatic test_window();
    tjob_t j;
    clear_stim();
    flag_at[PL-1] = 1'b1;
    post_flag     = 1'b1;
    start_job(mk_job($urandom, 3, $urandom), j);
    run_from_load(j);
    n_checks++;
    if (sol_valid !== 1'b0) begin
      n_fail++; $display("FAIL window_edges: got valid=%0b want 0", sol_valid);
    end
  endtask

  task automatic test_random();
    tjob_t j;
    logic [31:0] st;
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      st = $urandom;
      if ($urandom_range(0, 1) == 1) st = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      n = $urandom_range(1, 6);
      for (int c = 0; c < n + PL; c++) begin
        flag_at[c] = ($urandom_range(0, 2) == 0);
        pop_at[c]  = ($urandom_range(0, 2) == 0);
      end
      start_job(mk_job(st, n, $urandom), j);
      run_from_load(j);
      pop_all();
    end
  endtask

  task automatic test_overflow();
    tjob_t j;
    clear_stim();
    for (int c = PL; c < PL + 5; c++) flag_at[c] = 1'b1;
    flag_at[PL+6] = 1'b1;
    pop_at[PL+6]  = 1'b1;
    start_job(mk_job($urandom, 8, $urandom), j);
    run_from_load(j);
    n_checks++;
    if (sol_overflow !== 1'b1 || mq.size() != DEPTH) begin
      n_fail++;
      $display("FAIL overflow_flag: got ovf=%0b model=%0d want 1 %0d", sol_overflow, mq.size(), DEPTH);
    end
    pop_all();
  endtask

  task automatic test_abort();
    tjob_t a, b, c3;
    clear_stim();
    offer_c           = 1;
    offer_job         = mk_job($urandom, 4, $urandom);
    abort_c           = PL + 1;
    flag_at[PL]       = 1'b1;
    flag_at[PL+1]     = 1'b1;
    start_job(mk_job($urandom, 4, $urandom), a);
    run_from_load(a);
    b = pend_job;
    clear_stim();
    flag_at[0]        = 1'b1;
    flag_at[PL]       = 1'b1;
    run_from_load(b);
    pop_all();
    clear_stim();
    abort_c   = 3;
    post_flag = 1'b1;
    flag_at[2] = 1'b1;
    start_job(mk_job($urandom, 4, $urandom), c3);
    run_from_load(c3);
    pop_all();
  endtask

  task automatic test_reset_mid_run();
    tjob_t j;
    clear_stim();
    start_job(mk_job($urandom, 6, $urandom), j);
    repeat (3) tick();
    drive_job(mk_job($urandom, 2, $urandom));
    tick();
    job_valid = 1'b0;
    tick();
    #2 RST = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || job_ready !== 1'b1 || hs_rst_n !== 1'b1 || hs_write_en !== 1'b0 ||
        hs_nonce !== '0 || sol_overflow !== 1'b0 || sol_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%0b ready=%0b rst_n=%0b we=%0b nonce=%h ovf=%0b sv=%0b",
               busy, job_ready, hs_rst_n, hs_write_en, hs_nonce, sol_overflow, sol_valid);
    end
    mq.delete();
    exp_ovf  = 1'b0;
    next_id  = '0;
    pend_exp = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    clear_stim();
    flag_at[PL+1] = 1'b1;
    start_job(mk_job($urandom, 2, $urandom), j);
    run_from_load(j);
    n_checks++;
    if (sol_job_id !== '0) begin
      n_fail++; $display("FAIL id_after_reset: got %0d want 0", sol_job_id);
    end
    pop_all();
  endtask

  initial begin
    job_valid = 1'b0; abort = 1'b0; hs_valid = 1'b0; sol_ready = 1'b0;
    job_digest_init = '0; job_midstate = '0; job_merkle = '0; job_time = '0;
    job_target = '0; job_nonce_start = '0; job_nonce_end = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_window();
    test_random();
    test_abort();
    test_overflow();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha_job_scheduler.md
Name: sha_job_scheduler

Overview:
- Sequences the double-SHA256 mining datapath (`sha_hasher`).
- Accepts mining jobs from the host interface via a valid/ready handshake, double-buffers them, loads the hasher through its reset-load path, and runs it across a nonce range.
- Accounts for pipeline latency so that each solution flag from the hasher is tagged with the correct nonce, time and job ID.
- Queues tagged solutions in a small FIFO for the host.

Parameters:
- PIPE_LAT, 131, cycles from nonce issue to hasher solution flag.
- SOL_DEPTH, 4, solution FIFO depth (power of 2, ≥2).
- JOB_ID_W, 4, job ID width.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-low reset
- job_valid  in  1  host offers a job
- job_ready  out  1  pending buffer empty
- job_digest_init  in  256  SHA state added at end of first hash
- job_midstate  in  256  midstate into compression
- job_merkle  in  32  merkle tail word
- job_time  in  32  ntime
- job_target  in  32  compact nBits
- job_nonce_start  in  32  first nonce
- job_nonce_end  in  32  last nonce, inclusive
- abort  in  1  discard active job
- hs_rst_n  out  1  hasher reset/load strobe, active-low
- hs_write_en  out  1  hasher advance enable
- hs_digest_initial, hs_digest_in  out  256 each  active job fields
- hs_merkle, hs_time, hs_target, hs_nonce  out  32 each  active job fields
- hs_valid  in  1  hasher solution flag
- sol_valid  out  1  FIFO non-empty
- sol_ready  in  1  host pops a solution
- sol_nonce, sol_time  out  32 each  solution head entry
- sol_job_id  out  JOB_ID_W  solution head entry
- busy  out  1  FSM not IDLE
- sol_overflow  out  1  sticky; a solution was dropped

Behaviour:
- Reset values:
  - FSM = IDLE; all buffers, counters, FIFO and job ID cleared.
  - job_ready = 1; hs_rst_n = 1; hs_write_en = 0; all hs_* data = 0.
  - sol_valid = 0; busy = 0; sol_overflow = 0.
- Job handshake:
  - A transfer occurs when job_valid && job_ready; the job is stored in the pending buffer and its job ID is assigned by post-incrementing a JOB_ID_W-bit counter (wraps).
  - job_ready = 0 while the pending buffer is full.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE → LOAD when the pending buffer is full.
  - In the same edge, pending moves to active and pending is freed, so job_ready returns to 1 on the next cycle.
- LOAD (exactly 1 cycle):
  - hs_rst_n = 0 and hs_write_en = 0; the hasher latches hs_nonce/hs_time/hs_target.
  - Cycle counter c ← 0; remaining count N ← (end − start) mod 2^32, plus 1 in 33 bits.
  - → RUN.
- RUN and DRAIN:
  - hs_write_en = 1; c increments every cycle.
  - RUN → DRAIN when c == N−1, i.e. the last nonce has been issued.
  - DRAIN → IDLE when c == N+PIPE_LAT−1. If a job is pending at that point, go directly to LOAD instead (no IDLE cycle).
- Solution capture:
  - Accept hs_valid only when PIPE_LAT ≤ c < N+PIPE_LAT and the state is RUN or DRAIN.
  - Tag: offset k = c − PIPE_LAT. {sol_time, sol_nonce} = {job_time, job_nonce_start} + k, computed as a 64-bit add, so a nonce wrap carries into time exactly as the hasher does.
  - Tag the entry with the active job ID.
  - Flags outside the qualification window are ignored.
- Nonce range wrap: end < start is legal; the range runs through 0xFFFFFFFF→0. start == end gives N = 1.
- Solution FIFO:
  - Standard FWFT: push on an accepted flag, pop when sol_valid && sol_ready.
  - Simultaneous push and pop on a full FIFO: both succeed.
  - Push while full without a pop: the entry is dropped and sol_overflow is set; it is cleared only by RST.
- abort:
  - In LOAD, RUN or DRAIN: the active job is discarded immediately. Next state is LOAD if a job is pending, else IDLE.
  - In-flight flags are never captured, because the next LOAD resets the hasher and c.
  - abort in IDLE: no effect.
  - abort coincident with a job handshake: the handshake still completes.
- Reset mid-run: everything returns to reset values; the pending job is lost.

Optional Feature:
- Macro: SCHED_TIME_ROLL_EN.
- Defined: at DRAIN completion with no pending job, active job_time += 1, a new job ID is assigned, and the FSM → LOAD, rescanning the same nonce range indefinitely until abort or a new job arrives.
- Undefined: → IDLE as described above.

Decomposition:
- Package `sha_sched_pkg`:
  - FSM state enum.
  - job struct (digest_init, midstate, merkle, time, target, nonce_start, nonce_end, id).
  - solution struct (nonce, time, id).
  - PIPE_LAT default.
- Sub-module `sha_sol_fifo`: parameterised synchronous FWFT FIFO of solution structs with full/empty and overflow-safe push.

Test Plan:
- Job start=0x100, end=0x103, PIPE_LAT=8 (bench model), hs_valid pulsed at c=10 → sol_nonce=0x102; busy falls after 12 RUN/DRAIN cycles.
- start=0xFFFFFFFE, end=0x1, time=0x5000, flag at k=3 → sol_nonce=0x1, sol_time=0x5001; N=4.
- Second job offered during RUN → accepted, job_ready=0 until hand-off; LOAD follows DRAIN with no IDLE cycle; sol_job_id increments.
- Flags at c=PIPE_LAT−1 and c=N+PIPE_LAT → both ignored.
- SOL_DEPTH+1 flags with sol_ready=0 → 4 entries kept, sol_overflow=1; a pop on the full FIFO with a coincident push keeps the count at 4 and raises no new overflow.
- abort mid-RUN, then a flag 2 cycles later → no capture; LOAD of the pending job or IDLE. With SCHED_TIME_ROLL_EN: range completes → hs_time = job_time+1 on the rescan.
